program_loader: RTL
===================

PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 Parameter DATA_W, default 16, instruction word width.
REQ-002 Parameter ADDR_W, default 7, instruction memory address width, matching the 7-bit PC.
REQ-003 Parameter MEM_DEPTH, default 128, maximum program length in words.
REQ-004 Clk  input  1  system clock; all state updates on posedge Clk.
REQ-005 Reset  input  1  asynchronous, active-low system reset.
REQ-006 Start  input  1  one-cycle pulse that begins a load session.
REQ-007 In_Valid  input  1  upstream word valid.
REQ-008 In_Data  input  DATA_W  upstream word: header, program words, then checksum.
REQ-009 In_Ready  output  1  loader can accept a word this cycle.
REQ-010 Mem_Wr  output  1  instruction memory write strobe, one cycle per word.
REQ-011 Mem_Addr  output  ADDR_W  instruction memory write address.
REQ-012 Mem_Data  output  DATA_W  instruction memory write data.
REQ-013 Proc_Run  output  1  high releases the processor from reset; low holds it in reset.
REQ-014 Done  output  1  load completed with a correct checksum.
REQ-015 Error  output  1  load aborted (bad length or checksum mismatch).
REQ-016 Word_Count  output  ADDR_W+1  program words written in the current session.

Function
REQ-017 The state machine SHALL have the states IDLE, HEADER, LOAD, CHECK, DONE and ERROR.
REQ-018 A word SHALL be accepted only in a cycle where In_Valid and In_Ready are both high.
REQ-019 In_Ready SHALL be high only in HEADER, LOAD and CHECK, and SHALL be combinationally independent of In_Valid.
REQ-020 Transitions:
- IDLE -> HEADER on Start.
- HEADER -> LOAD on accepting length N with 1<=N<=MEM_DEPTH; stored N = In_Data.
- HEADER -> ERROR on accepting N=0 or N>MEM_DEPTH.
- LOAD -> CHECK on accepting the Nth program word.
- CHECK -> DONE on accepting a word equal to the checksum.
- CHECK -> ERROR on accepting any other word.
REQ-021 The checksum SHALL be the sum of all N program words modulo 2^DATA_W; the header SHALL be excluded.
REQ-022 A program word accepted at posedge k SHALL produce Mem_Wr=1 with the matching Mem_Addr/Mem_Data for exactly the cycle after posedge k (one-cycle registered latency).
REQ-023 Mem_Addr SHALL start at 0 for each session and increment by 1 per written word; it SHALL never wrap, because N<=MEM_DEPTH.
REQ-024 Word_Count SHALL equal the number of Mem_Wr pulses issued since the session began.
REQ-025 Proc_Run SHALL be high only in DONE.
REQ-026 Done SHALL be high only in DONE, and Error SHALL be high only in ERROR.
REQ-027 Start in HEADER, LOAD or CHECK SHALL be ignored.
REQ-028 Start in DONE or ERROR SHALL move to HEADER and clear Word_Count, Mem_Addr and the checksum accumulator; Proc_Run SHALL drop the next cycle.
REQ-029 Back-to-back accepts on consecutive cycles SHALL be supported with no bubble.
REQ-030 In_Valid gaps SHALL stall progress without changing state or counters.

Reset
REQ-031 Asserting Reset low SHALL immediately force IDLE, with In_Ready=0, Mem_Wr=0, Mem_Addr=0, Mem_Data=0, Proc_Run=0, Done=0, Error=0 and Word_Count=0, the checksum cleared and the stored N cleared.
REQ-032 Reset asserted mid-load SHALL abort the session; no further Mem_Wr SHALL be issued, and words already written SHALL remain in memory.

Structure
REQ-033 A shared package loader_pkg SHALL hold the state enum type and the DATA_W/ADDR_W/MEM_DEPTH default constants.
REQ-034 The checksum accumulator (clear, add-enable, sum output) SHALL be a sub-module named loader_checksum.

Verification
REQ-035 Normal load: Start; send 3, 16'h1234, 16'h0001, 16'h5000, checksum 16'h6235 -> Mem_Wr at addresses 0,1,2 with those data; Done=1, Proc_Run=1, Word_Count=3.
REQ-036 Bad checksum: same program, last word 16'h6236 -> three writes, then Error=1, Proc_Run=0 and Done=0.
REQ-037 Bad length: Start; header 0, then separately header 129 -> ERROR after the header, no Mem_Wr, In_Ready=0.
REQ-038 Checksum wrap: N=2, words 16'hFFFF and 16'h0002, checksum 16'h0001 -> Done=1.
REQ-039 Full program: N=128 with In_Valid held high -> 128 consecutive Mem_Wr pulses, final Mem_Addr=7'h7F, Word_Count=128, Done=1.
REQ-040 Reset mid-load: Reset low after the 2nd of 5 words -> outputs at their REQ-031 values within the same cycle, no further writes; a Start after Reset high begins a new session at address 0.

Source files
------------

// File: rtl/loader_pkg.sv
// Shared types and default sizes for the program loader and its checksum unit.
package loader_pkg;

  localparam int LOADER_DATA_W    = 16;
  localparam int LOADER_ADDR_W    = 7;
  localparam int LOADER_MEM_DEPTH = 128;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HEADER = 3'd1,
    ST_LOAD   = 3'd2,
    ST_CHECK  = 3'd3,
    ST_DONE   = 3'd4,
    ST_ERROR  = 3'd5
  } loader_state_t;

endpackage

// File: rtl/loader_checksum.sv
// Running sum of program words, modulo 2^DATA_W, used to validate the trailing checksum word.
module loader_checksum
  import loader_pkg::*;
#(
  parameter int DATA_W = LOADER_DATA_W
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              clr,
  input  logic              add_en,
  input  logic [DATA_W-1:0] add_data,
  output logic [DATA_W-1:0] sum
);

  logic [DATA_W-1:0] sum_r;

  // Accumulator register; a session clear takes priority over an add
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      sum_r <= {DATA_W{1'b0}};
    end else if (clr) begin
      sum_r <= {DATA_W{1'b0}};
    end else if (add_en) begin
      sum_r <= sum_r + add_data;
    end else begin
      sum_r <= sum_r;
    end
  end

  assign sum = sum_r;

endmodule

// File: rtl/program_loader.sv
// Streams a length-prefixed, checksummed program into instruction memory and
// releases the processor only after the checksum matches.
module program_loader
  import loader_pkg::*;
#(
  parameter int DATA_W    = LOADER_DATA_W,
  parameter int ADDR_W    = LOADER_ADDR_W,
  parameter int MEM_DEPTH = LOADER_MEM_DEPTH
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  input  logic              In_Valid,
  input  logic [DATA_W-1:0] In_Data,
  output logic              In_Ready,
  output logic              Mem_Wr,
  output logic [ADDR_W-1:0] Mem_Addr,
  output logic [DATA_W-1:0] Mem_Data,
  output logic              Proc_Run,
  output logic              Done,
  output logic              Error,
  output logic [ADDR_W:0]   Word_Count
);

  loader_state_t     state_r, state_nxt_s;
  logic [ADDR_W:0]   n_r, word_count_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [DATA_W-1:0] mem_data_r, sum_s;
  logic              ready_r, mem_wr_r, run_r, done_r, error_r;
  logic              accept_s, len_ok_s, last_word_s;
  logic              session_start_s, hdr_take_s, load_take_s;

  assign accept_s    = In_Valid & ready_r;
  assign len_ok_s    = (In_Data != {DATA_W{1'b0}}) && (In_Data <= DATA_W'(MEM_DEPTH));
  assign last_word_s = ((word_count_r + {{ADDR_W{1'b0}}, 1'b1}) == n_r);

  // Next-state logic and the per-cycle datapath strobes
  always_comb begin
    state_nxt_s     = state_r;
    session_start_s = 1'b0;
    hdr_take_s      = 1'b0;
    load_take_s     = 1'b0;
    case (state_r)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (Start) begin
          state_nxt_s     = ST_HEADER;
          session_start_s = 1'b1;
        end else begin
          state_nxt_s = state_r;
        end
      end
      ST_HEADER: begin
        if (accept_s) begin
          if (len_ok_s) begin
            state_nxt_s = ST_LOAD;
            hdr_take_s  = 1'b1;
          end else begin
            state_nxt_s = ST_ERROR;
          end
        end else begin
          state_nxt_s = ST_HEADER;
        end
      end
      ST_LOAD: begin
        if (accept_s) begin
          load_take_s = 1'b1;
          if (last_word_s) begin
            state_nxt_s = ST_CHECK;
          end else begin
            state_nxt_s = ST_LOAD;
          end
        end else begin
          state_nxt_s = ST_LOAD;
        end
      end
      ST_CHECK: begin
        if (accept_s) begin
          if (In_Data == sum_s) begin
            state_nxt_s = ST_DONE;
          end else begin
            state_nxt_s = ST_ERROR;
          end
        end else begin
          state_nxt_s = ST_CHECK;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State register; status flags are registered from the next state so they track it exactly
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_r <= ST_IDLE;
      ready_r <= 1'b0;
      run_r   <= 1'b0;
      done_r  <= 1'b0;
      error_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      ready_r <= (state_nxt_s == ST_HEADER) || (state_nxt_s == ST_LOAD) ||
                 (state_nxt_s == ST_CHECK);
      run_r   <= (state_nxt_s == ST_DONE);
      done_r  <= (state_nxt_s == ST_DONE);
      error_r <= (state_nxt_s == ST_ERROR);
    end
  end

  // Memory write port, word counter and stored program length
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      n_r          <= {(ADDR_W+1){1'b0}};
      word_count_r <= {(ADDR_W+1){1'b0}};
      mem_addr_r   <= {ADDR_W{1'b0}};
      mem_data_r   <= {DATA_W{1'b0}};
      mem_wr_r     <= 1'b0;
    end else begin
      mem_wr_r <= load_take_s;
      if (session_start_s) begin
        word_count_r <= {(ADDR_W+1){1'b0}};
        mem_addr_r   <= {ADDR_W{1'b0}};
      end else if (load_take_s) begin
        // The count before increment is the address of the word being written
        word_count_r <= word_count_r + {{ADDR_W{1'b0}}, 1'b1};
        mem_addr_r   <= word_count_r[ADDR_W-1:0];
        mem_data_r   <= In_Data;
      end else begin
        word_count_r <= word_count_r;
        mem_addr_r   <= mem_addr_r;
        mem_data_r   <= mem_data_r;
      end
      if (hdr_take_s) begin
        n_r <= In_Data[ADDR_W:0];
      end else begin
        n_r <= n_r;
      end
    end
  end

  loader_checksum #(.DATA_W(DATA_W)) u_checksum (
    .Clk      (Clk),
    .Reset    (Reset),
    .clr      (session_start_s),
    .add_en   (load_take_s),
    .add_data (In_Data),
    .sum      (sum_s)
  );

  assign In_Ready   = ready_r;
  assign Mem_Wr     = mem_wr_r;
  assign Mem_Addr   = mem_addr_r;
  assign Mem_Data   = mem_data_r;
  assign Proc_Run   = run_r;
  assign Done       = done_r;
  assign Error      = error_r;
  assign Word_Count = word_count_r;

endmodule
